conv_win_seq: RTL
=================

CONV_WIN_SEQ -- requirements
Module: conv_win_seq

Interface
REQ-001 SHALL have parameter ROW, default 8: feature-map rows, range 1..255.
REQ-002 SHALL have parameter COL, default 8: feature-map columns, range 1..255.
REQ-003 SHALL have parameter K, default 3: square kernel size, with 1 <= K <= min(ROW, COL).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: begin a load-then-scan job.
REQ-007 SHALL have ports load_valid (input, 1), load_data (input, 16) and load_ready (output, 1): loader stream.
REQ-008 SHALL have ports mem_we (output, 1), mem_data_in (output, 16), mem_addr_write (output, 16) and mem_addr_read (output, 16): memory drive; addresses are {row[7:0], col[7:0]}.
REQ-009 SHALL have port mem_data_out, input, 16 bits: memory read data, valid exactly one cycle after its address is issued.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, 16, signed): tap stream to the MAC.
REQ-011 SHALL have ports out_last_tap and out_last_win, outputs, 1 bit each: qualified by out_valid.
REQ-012 SHALL have ports busy and done, outputs, 1 bit each.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SCAN and FIN.
- IDLE -> LOAD on start.
- LOAD -> SCAN after the ROW*COL-th accepted word.
- SCAN -> FIN when the final tap is popped from the output.
- FIN -> IDLE unconditionally after one cycle.
REQ-014 SHALL ignore start in every state other than IDLE.
REQ-015 SHALL hold busy = 1 in LOAD and SCAN, and busy = 0 otherwise.
REQ-016 SHALL pulse done = 1 for exactly one cycle, in FIN.
REQ-017 SHALL drive load_ready = 1 only in LOAD.
- A beat is accepted when load_valid && load_ready.
- mem_we = 1 in that same cycle, with mem_data_in = load_data and mem_addr_write = current row/col.
REQ-018 SHALL write load beats in row-major order: col increments, wrapping from COL-1 to 0 with row+1.
REQ-019 SHALL keep mem_we = 0 in every cycle with no accepted load beat, and always in SCAN.
REQ-020 SHALL drive mem_addr_write = 0 and mem_addr_read = 0 whenever the respective address is not in use.
REQ-021 SHALL visit window origins (r0, c0) in SCAN in row-major order, with r0 in 0..ROW-K and c0 in 0..COL-K.
REQ-022 SHALL read the taps of each window in row-major order (kr, kc in 0..K-1) at address {r0+kr, c0+kc}.
REQ-023 SHALL buffer output in a 2-entry FIFO.
- occ = FIFO occupancy; infl = reads issued but not yet captured (0 or 1).
- pop = out_valid && out_ready.
- A read SHALL be issued in a cycle only if occ + infl - pop < 2 and taps remain.
REQ-024 SHALL capture mem_data_out into the FIFO at the end of the cycle following issue, together with the tap's last_tap/last_win flags.
REQ-025 SHALL keep out_valid = (occ > 0), with out_data and flags taken from the FIFO head.
REQ-026 SHALL hold out_data and flags stable while out_valid && !out_ready.
REQ-027 SHALL set out_last_tap on tap (K-1, K-1) of each window.
REQ-028 SHALL set out_last_win on every tap of window (ROW-K, COL-K).
REQ-029 SHALL sustain 1 tap per cycle with out_ready held high; first out_valid 2 cycles after SCAN entry.
REQ-030 SHALL allow simultaneous push and pop in one cycle, leaving occ unchanged.
REQ-031 SHALL never issue a read that would overflow the FIFO, under any out_ready pattern.
REQ-032 SHALL produce exactly (ROW-K+1)*(COL-K+1)*K*K taps per job, with no drop or duplicate.

Reset
REQ-033 SHALL, when rst_n = 0 at a clock edge:
- force the FSM to IDLE;
- set occ, infl and all counters to 0;
- drive busy, done, load_ready, mem_we, out_valid and all flags to 0;
- drive out_data and all addresses to 0.
REQ-034 SHALL discard any job in progress on reset, including mid-LOAD and mid-SCAN, without resuming it; the in-flight read is dropped.

Verification
REQ-035 Full job, ROW=COL=4, K=3, data = row*4+col, out_ready = 1:
- 36 taps total.
- Window 0 yields 0,1,2,4,5,6,8,9,10.
- Window 3 yields 5,6,7,9,10,11,13,14,15; out_last_win is high on all nine, and the tap with value 15 also has out_last_tap.
- done pulses once.
REQ-036 Load stalls: load_valid toggling 1,0,1,0 -> mem_we only on valid beats, addresses contiguous 0x0000..0x0303, SCAN entered only after 16 beats.
REQ-037 Backpressure: out_ready low for 5 cycles mid-window -> occ never exceeds 2, out_data stable, sequence identical to REQ-035.
REQ-038 Random out_ready (50%) over 3 jobs -> each job yields 36 taps in order; start asserted during busy is ignored.
REQ-039 Reset mid-SCAN after 10 taps -> next cycle all outputs 0 and state IDLE; a new start replays the full REQ-035 sequence from tap 0.
REQ-040 K=1, ROW=COL=2 -> 4 taps 0,1,2,3, each with out_last_tap = 1, and only tap 3 with out_last_win = 1.

Source files
------------

// File: rtl/conv_win_seq.sv
// conv_win_seq: loads a ROW x COL map into external RAM, then streams
// every KxK window tap, row-major, through a 2-entry output FIFO.
module conv_win_seq #(
  parameter int ROW = 8,
  parameter int COL = 8,
  parameter int K   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               load_valid,
  input  logic [15:0]        load_data,
  output logic               load_ready,
  output logic               mem_we,
  output logic [15:0]        mem_data_in,
  output logic [15:0]        mem_addr_write,
  output logic [15:0]        mem_addr_read,
  input  logic [15:0]        mem_data_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_data,
  output logic               out_last_tap,
  output logic               out_last_win,
  output logic               busy,
  output logic               done
);

  localparam logic [7:0] RLST = 8'(ROW - 1);
  localparam logic [7:0] CLST = 8'(COL - 1);
  localparam logic [7:0] KLST = 8'(K - 1);
  localparam logic [7:0] RWIN = 8'(ROW - K);
  localparam logic [7:0] CWIN = 8'(COL - K);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCAN,
    FIN
  } state_t;

  typedef struct packed {
    logic [15:0] d;
    logic        lt;
    logic        lw;
  } ent_t;

  state_t     st_q, st_d;
  logic [7:0] lr_q, lr_d, lc_q, lc_d;
  logic [7:0] r0_q, r0_d, c0_q, c0_d;
  logic [7:0] kr_q, kr_d, kc_q, kc_d;
  logic       all_q, all_d;
  logic [1:0] occ_q, occ_d;
  logic       inf_q, inf_d;
  logic       ilt_q, ilt_d, ilw_q, ilw_d;
  ent_t       e0_q, e0_d, e1_q, e1_d;
  logic       busy_q, done_q, rdy_q;

  logic       acc, pop, push, room, issue;
  logic [1:0] widx;
  logic [7:0] rd_r, rd_c;
  ent_t       nw;

  assign out_valid = (occ_q != 2'd0);
  assign acc       = load_valid && rdy_q;
  assign pop       = out_valid && out_ready;
  assign push      = inf_q;
  // a read may go out only if its data is sure to find a free slot
  assign room      = ({1'b0, occ_q} + {2'b0, inf_q})
                   < (3'd2 + {2'b0, pop});
  assign issue     = (st_q == SCAN) && !all_q && room;
  assign rd_r      = r0_q + kr_q;
  assign rd_c      = c0_q + kc_q;
  assign widx      = occ_q - {1'b0, pop};
  assign nw        = '{d: mem_data_out, lt: ilt_q, lw: ilw_q};

  always_comb begin
    st_d  = st_q;
    lr_d  = lr_q;
    lc_d  = lc_q;
    r0_d  = r0_q;
    c0_d  = c0_q;
    kr_d  = kr_q;
    kc_d  = kc_q;
    all_d = all_q;
    unique case (st_q)
      IDLE: begin
        if (start) begin
          st_d = LOAD;
          lr_d = '0;
          lc_d = '0;
        end
      end
      LOAD: begin
        if (acc) begin
          if (lc_q == CLST) begin
            lc_d = '0;
            lr_d = lr_q + 8'd1;
          end else begin
            lc_d = lc_q + 8'd1;
          end
          if (lr_q == RLST && lc_q == CLST) begin
            st_d  = SCAN;
            lr_d  = '0;
            r0_d  = '0;
            c0_d  = '0;
            kr_d  = '0;
            kc_d  = '0;
            all_d = 1'b0;
          end
        end
      end
      SCAN: begin
        if (issue) begin
          if (kc_q != KLST) begin
            kc_d = kc_q + 8'd1;
          end else begin
            kc_d = '0;
            if (kr_q != KLST) begin
              kr_d = kr_q + 8'd1;
            end else begin
              kr_d = '0;
              if (c0_q != CWIN) begin
                c0_d = c0_q + 8'd1;
              end else begin
                c0_d = '0;
                if (r0_q != RWIN) r0_d = r0_q + 8'd1;
                else all_d = 1'b1;
              end
            end
          end
        end
        if (pop && e0_q.lt && e0_q.lw) st_d = FIN;
      end
      FIN: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    inf_d = issue;
    ilt_d = (kr_q == KLST) && (kc_q == KLST);
    ilw_d = (r0_q == RWIN) && (c0_q == CWIN);
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (pop) e0_d = e1_q;
    if (push) begin
      if (widx == 2'd0) e0_d = nw;
      else e1_d = nw;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      lr_q   <= '0;
      lc_q   <= '0;
      r0_q   <= '0;
      c0_q   <= '0;
      kr_q   <= '0;
      kc_q   <= '0;
      all_q  <= 1'b0;
      occ_q  <= '0;
      inf_q  <= 1'b0;
      ilt_q  <= 1'b0;
      ilw_q  <= 1'b0;
      e0_q   <= '0;
      e1_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      lr_q   <= lr_d;
      lc_q   <= lc_d;
      r0_q   <= r0_d;
      c0_q   <= c0_d;
      kr_q   <= kr_d;
      kc_q   <= kc_d;
      all_q  <= all_d;
      occ_q  <= occ_d;
      inf_q  <= inf_d;
      ilt_q  <= ilt_d;
      ilw_q  <= ilw_d;
      e0_q   <= e0_d;
      e1_q   <= e1_d;
      busy_q <= (st_d == LOAD) || (st_d == SCAN);
      done_q <= (st_d == FIN);
      rdy_q  <= (st_d == LOAD);
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign load_ready     = rdy_q;
  assign mem_we         = acc;
  assign mem_data_in    = acc ? load_data : '0;
  assign mem_addr_write = acc ? {lr_q, lc_q} : '0;
  assign mem_addr_read  = issue ? {rd_r, rd_c} : '0;
  assign out_data       = out_valid ? $signed(e0_q.d) : '0;
  assign out_last_tap   = out_valid && e0_q.lt;
  assign out_last_win   = out_valid && e0_q.lw;

endmodule
